// File: rtl/ps2_piano_pkg.sv
// Shared scan-code constants, decoder state encoding and the note lookup
// used by the PS/2 piano scan-code decoder.
package ps2_piano_pkg;

  localparam int unsigned NUM_NOTES = 8;
  localparam int unsigned NOTE_W    = 3;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_NOTE_C4 = 8'h1C;  // A
  localparam logic [7:0] SC_NOTE_D  = 8'h1B;  // S
  localparam logic [7:0] SC_NOTE_E  = 8'h23;  // D
  localparam logic [7:0] SC_NOTE_F  = 8'h2B;  // F
  localparam logic [7:0] SC_NOTE_G  = 8'h34;  // G
  localparam logic [7:0] SC_NOTE_A  = 8'h33;  // H
  localparam logic [7:0] SC_NOTE_B  = 8'h3B;  // J
  localparam logic [7:0] SC_NOTE_C5 = 8'h42;  // K

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BREAK     = 2'd1,
    EXT       = 2'd2,
    EXT_BREAK = 2'd3
  } dec_state_e;

  // Returns {hit, note index}; hit=0 for any byte outside the piano row.
  function automatic logic [NOTE_W:0] scancode_to_note(input logic [7:0] code);
    logic [NOTE_W:0] res;
    res = '0;
    unique case (code)
      SC_NOTE_C4: res = {1'b1, 3'd0};
      SC_NOTE_D:  res = {1'b1, 3'd1};
      SC_NOTE_E:  res = {1'b1, 3'd2};
      SC_NOTE_F:  res = {1'b1, 3'd3};
      SC_NOTE_G:  res = {1'b1, 3'd4};
      SC_NOTE_A:  res = {1'b1, 3'd5};
      SC_NOTE_B:  res = {1'b1, 3'd6};
      SC_NOTE_C5: res = {1'b1, 3'd7};
      default:    res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/note_priority_enc.sv
// Lowest-set-bit encoder over the held-key bitmap; purely combinational,
// the parent registers the result.
module note_priority_enc
  import ps2_piano_pkg::*;
(
  input  logic [NUM_NOTES-1:0] keys,
  output logic                 any_c,
  output logic [NOTE_W-1:0]    idx_c
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any_c = |keys;
    idx_c = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (keys[i]) idx_c = NOTE_W'(i);
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Decodes set-2 make/break byte sequences into held-note state, one-cycle
// press/release events and a lowest-note-wins active note.
module ps2_scancode_decoder
  import ps2_piano_pkg::*;
#(
  parameter int unsigned PREFIX_TIMEOUT = 27_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_data_en,
  input  logic                 all_off,
  output logic [NUM_NOTES-1:0] key_down,
  output logic                 evt_valid,
  output logic                 evt_make,
  output logic [NOTE_W-1:0]    evt_note,
  output logic                 note_active,
  output logic [NOTE_W-1:0]    active_note
);

  localparam int unsigned TIMER_W = $clog2(PREFIX_TIMEOUT + 1);

  dec_state_e           state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [NUM_NOTES-1:0] key_down_q, key_down_d;
  logic                 evt_valid_q, evt_valid_d;
  logic                 evt_make_q, evt_make_d;
  logic [NOTE_W-1:0]    evt_note_q, evt_note_d;
  logic                 note_active_q, note_active_d;
  logic [NOTE_W-1:0]    active_note_q, active_note_d;

  logic                 enc_any_c;
  logic [NOTE_W-1:0]    enc_idx_c;
  logic [NOTE_W:0]      lookup;
  logic                 hit;
  logic [NOTE_W-1:0]    idx;
  logic                 do_make;
  logic                 do_release;

  note_priority_enc u_prio (
    .keys  (key_down_q),
    .any_c (enc_any_c),
    .idx_c (enc_idx_c)
  );

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    key_down_d    = key_down_q;
    evt_valid_d   = 1'b0;
    evt_make_d    = 1'b0;
    evt_note_d    = '0;
    note_active_d = enc_any_c;
    active_note_d = enc_idx_c;
    do_make       = 1'b0;
    do_release    = 1'b0;
    lookup        = scancode_to_note(rx_data);
    hit           = lookup[NOTE_W];
    idx           = lookup[NOTE_W-1:0];

    if (rx_data_en) begin
      // A byte always wins over a timeout landing in the same cycle.
      timer_d = '0;
      unique case (state_q)
        IDLE: begin
          if (rx_data == SC_BREAK)    state_d = BREAK;
          else if (rx_data == SC_EXT) state_d = EXT;
          else                        do_make = hit;
        end
        BREAK: begin
          if (rx_data == SC_BREAK) begin
            state_d = BREAK;
          end else begin
            state_d    = IDLE;
            do_release = hit;
          end
        end
        EXT: begin
          if (rx_data == SC_BREAK)    state_d = EXT_BREAK;
          else if (rx_data == SC_EXT) state_d = EXT;
          else                        state_d = IDLE;
        end
        EXT_BREAK: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      timer_d = '0;
    end else if (timer_q == TIMER_W'(PREFIX_TIMEOUT - 1)) begin
      state_d = IDLE;
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TIMER_W'(1);
    end

    // Typematic repeats and releases of unheld keys change nothing.
    if (do_make && !key_down_q[idx]) begin
      key_down_d[idx] = 1'b1;
      evt_valid_d     = 1'b1;
      evt_make_d      = 1'b1;
      evt_note_d      = idx;
    end
    if (do_release && key_down_q[idx]) begin
      key_down_d[idx] = 1'b0;
      evt_valid_d     = 1'b1;
      evt_make_d      = 1'b0;
      evt_note_d      = idx;
    end

    if (all_off) begin
      state_d       = IDLE;
      timer_d       = '0;
      key_down_d    = '0;
      evt_valid_d   = 1'b0;
      evt_make_d    = 1'b0;
      evt_note_d    = '0;
      note_active_d = 1'b0;
      active_note_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      key_down_q    <= '0;
      evt_valid_q   <= 1'b0;
      evt_make_q    <= 1'b0;
      evt_note_q    <= '0;
      note_active_q <= 1'b0;
      active_note_q <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      key_down_q    <= key_down_d;
      evt_valid_q   <= evt_valid_d;
      evt_make_q    <= evt_make_d;
      evt_note_q    <= evt_note_d;
      note_active_q <= note_active_d;
      active_note_q <= active_note_d;
    end
  end

  assign key_down    = key_down_q;
  assign evt_valid   = evt_valid_q;
  assign evt_make    = evt_make_q;
  assign evt_note    = evt_note_q;
  assign note_active = note_active_q;
  assign active_note = active_note_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for the PS/2 piano scan-code decoder with a short prefix timeout.
module tb_ps2_scancode_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_data_en;
  logic       all_off;
  logic [7:0] key_down;
  logic       evt_valid;
  logic       evt_make;
  logic [2:0] evt_note;
  logic       note_active;
  logic [2:0] active_note;

  int checks  = 0;
  int errors  = 0;
  int evt_cnt = 0;
  int base;

  ps2_scancode_decoder #(.PREFIX_TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_data_en  (rx_data_en),
    .all_off     (all_off),
    .key_down    (key_down),
    .evt_valid   (evt_valid),
    .evt_make    (evt_make),
    .evt_note    (evt_note),
    .note_active (note_active),
    .active_note (active_note)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every evt_valid cycle so stray pulses are caught.
  always @(posedge clk) begin
    if (!reset && evt_valid) evt_cnt <= evt_cnt + 1;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the byte's outputs visible.
  task automatic send(input logic [7:0] b);
    rx_data    = b;
    rx_data_en = 1'b1;
    @(negedge clk);
    rx_data_en = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset      = 1'b1;
    all_off    = 1'b0;
    rx_data    = 8'h00;
    rx_data_en = 1'b0;
    tick(3);
    check("rst_key_down", key_down, 8'h00);
    check("rst_evt_valid", {7'd0, evt_valid}, 8'h00);
    check("rst_evt_make", {7'd0, evt_make}, 8'h00);
    check("rst_evt_note", {5'd0, evt_note}, 8'h00);
    check("rst_note_active", {7'd0, note_active}, 8'h00);
    check("rst_active_note", {5'd0, active_note}, 8'h00);
    reset = 1'b0;
    tick(1);

    // Press and release A
    send(8'h1C);
    check("a_press_valid", {7'd0, evt_valid}, 8'h01);
    check("a_press_make", {7'd0, evt_make}, 8'h01);
    check("a_press_note", {5'd0, evt_note}, 8'h00);
    check("a_press_keys", key_down, 8'h01);
    tick(1);
    check("a_pulse_width", {7'd0, evt_valid}, 8'h00);
    check("a_active", {7'd0, note_active}, 8'h01);
    check("a_active_note", {5'd0, active_note}, 8'h00);
    send(8'hF0);
    check("a_prefix_no_evt", {7'd0, evt_valid}, 8'h00);
    send(8'h1C);
    check("a_rel_valid", {7'd0, evt_valid}, 8'h01);
    check("a_rel_make", {7'd0, evt_make}, 8'h00);
    check("a_rel_note", {5'd0, evt_note}, 8'h00);
    check("a_rel_keys", key_down, 8'h00);
    tick(1);
    check("a_inactive", {7'd0, note_active}, 8'h00);

    // Typematic repeat of D, back-to-back bytes
    base = evt_cnt;
    send(8'h23);
    check("typ_press_note", {5'd0, evt_note}, 8'h02);
    send(8'h23);
    check("typ_repeat_no_evt", {7'd0, evt_valid}, 8'h00);
    send(8'h23);
    check("typ_keys", key_down, 8'h04);
    send(8'hF0);
    send(8'h23);
    check("typ_rel_make", {7'd0, evt_make}, 8'h00);
    check("typ_rel_keys", key_down, 8'h00);
    tick(2);
    check("typ_evt_count", 8'(evt_cnt - base), 8'h02);

    // Extended and unmapped codes never drive notes
    base = evt_cnt;
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h15); send(8'hFA); send(8'hAA);
    check("ext_keys", key_down, 8'h00);
    send(8'h1B);
    check("ext_s_valid", {7'd0, evt_valid}, 8'h01);
    check("ext_s_make", {7'd0, evt_make}, 8'h01);
    check("ext_s_note", {5'd0, evt_note}, 8'h01);
    send(8'hE0); send(8'h1C);
    check("ext_e0_mapped_ignored", key_down, 8'h02);
    send(8'hF0); send(8'h1B);
    check("ext_s_rel_keys", key_down, 8'h00);
    tick(2);
    check("ext_evt_count", 8'(evt_cnt - base), 8'h02);

    // Chord: lowest held note wins
    send(8'h42); send(8'h23); send(8'h1C);
    check("chord_keys", key_down, 8'h85);
    tick(1);
    check("chord_active_0", {5'd0, active_note}, 8'h00);
    send(8'hF0); send(8'hF0); send(8'h1C);
    check("chord_double_f0_rel", key_down, 8'h84);
    tick(1);
    check("chord_active_2", {5'd0, active_note}, 8'h02);
    send(8'hF0); send(8'h23);
    tick(1);
    check("chord_active_7", {5'd0, active_note}, 8'h07);
    check("chord_still_active", {7'd0, note_active}, 8'h01);
    send(8'hF0); send(8'h42);
    tick(1);
    check("chord_none_active", {7'd0, note_active}, 8'h00);
    check("chord_none_note", {5'd0, active_note}, 8'h00);

    // Prefix timeout: stale F0 dropped, next byte is a make
    send(8'hF0);
    tick(16);
    send(8'h1C);
    check("tmo_valid", {7'd0, evt_valid}, 8'h01);
    check("tmo_make", {7'd0, evt_make}, 8'h01);
    check("tmo_keys", key_down, 8'h01);
    // Byte landing on the timeout cycle is still taken as a release
    send(8'hF0);
    tick(15);
    send(8'h1C);
    check("tmo_edge_valid", {7'd0, evt_valid}, 8'h01);
    check("tmo_edge_make", {7'd0, evt_make}, 8'h00);
    check("tmo_edge_keys", key_down, 8'h00);

    // all_off mid-sequence overrides a same-cycle byte
    send(8'h1C); send(8'h34);
    check("off_keys_before", key_down, 8'h11);
    send(8'hF0);
    all_off    = 1'b1;
    rx_data    = 8'h1C;
    rx_data_en = 1'b1;
    @(negedge clk);
    all_off    = 1'b0;
    rx_data_en = 1'b0;
    check("off_keys", key_down, 8'h00);
    check("off_no_evt", {7'd0, evt_valid}, 8'h00);
    check("off_inactive", {7'd0, note_active}, 8'h00);
    send(8'h34);
    check("off_g_make", {7'd0, evt_make}, 8'h01);
    check("off_g_note", {5'd0, evt_note}, 8'h04);
    check("off_g_keys", key_down, 8'h10);

    // Reset mid-prefix returns to IDLE
    send(8'hF0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_mid_keys", key_down, 8'h00);
    send(8'h1C);
    check("rst_mid_make", {7'd0, evt_make}, 8'h01);
    check("rst_mid_keysafter", key_down, 8'h01);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
